// File: rtl/alarm_responder.sv
// Alarm ringing controller: rings on time==alarm, handles dismiss, snooze with 24h wrap, auto-silence.
// Latency: every output is a flop; a condition sampled at a clock edge shows on the outputs right after that edge.
// Backpressure: none; key pulses are single-cycle and are ignored in states where they have no meaning.
// Ports: clk/reset_n (sync, active-low), alarm_enable, time_*/alarm_* (BCD-free binary h/m),
//   snooze/dismiss pulses, buzzer_on/ringing/snoozed/snooze_count outputs.
module alarm_responder #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BEEP_HZ     = 2,
   parameter int SNOOZE_MIN  = 5,
   parameter int TIMEOUT_MIN = 10,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       alarm_enable,
   input  logic [4:0] time_hours,
   input  logic [5:0] time_minutes,
   input  logic [4:0] alarm_hours,
   input  logic [5:0] alarm_minutes,
   input  logic       snooze,
   input  logic       dismiss,
   output logic       buzzer_on,
   output logic       ringing,
   output logic       snoozed,
   output logic [2:0] snooze_count
);

   localparam int HALF = CLK_HZ / (2 * BEEP_HZ);
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HW-1:0] HALF_LAST   = HW'(HALF - 1);
   localparam logic [2:0]    MAX_SNZ     = 3'(MAX_SNOOZE);
   localparam logic [5:0]    TIMEOUT     = 6'(TIMEOUT_MIN);
   localparam logic [6:0]    SNOOZE_ADD  = 7'(SNOOZE_MIN);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RINGING = 2'd1,
      S_SNOOZE  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t state, state_nxt;

   // datapath registers
   logic [HW-1:0] beep_cnt;
   logic          beep_phase;
   logic [5:0]    prev_minutes;
   logic [5:0]    roll_cnt;
   logic [4:0]    target_hours;
   logic [5:0]    target_minutes;

   // next values of datapath and registered outputs
   logic [HW-1:0] beep_cnt_nxt;
   logic          beep_phase_nxt;
   logic [5:0]    roll_cnt_nxt;
   logic [4:0]    target_hours_nxt;
   logic [5:0]    target_minutes_nxt;
   logic [2:0]    snooze_count_nxt;
   logic          ringing_nxt;
   logic          snoozed_nxt;
   logic          buzzer_on_nxt;

   logic       time_match;
   logic       target_match;
   logic       rollover;
   logic [5:0] roll_seen;
   logic       enter_ring;
   logic       take_snooze;

   // snooze target arithmetic
   logic [6:0] snz_m_sum;
   logic [4:0] snz_h_inc;
   logic [5:0] snz_m;
   logic [4:0] snz_h;

   assign time_match   = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
   assign target_match = (time_hours == target_hours) && (time_minutes == target_minutes);
   // any change of the minute field counts as one rollover, including jumps
   assign rollover     = (time_minutes != prev_minutes);
   // include the rollover happening this very cycle so timeout fires on the rollover edge itself
   assign roll_seen    = roll_cnt + {5'd0, rollover};

   always_comb begin
      snz_m_sum = {1'b0, time_minutes} + SNOOZE_ADD;
      snz_h_inc = time_hours;
      snz_m     = snz_m_sum[5:0];
      if (snz_m_sum >= 7'd60) begin
         snz_m     = 6'(snz_m_sum - 7'd60);
         snz_h_inc = time_hours + 5'd1;
      end
      snz_h = (snz_h_inc == 5'd24) ? 5'd0 : snz_h_inc;
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      if (!alarm_enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (time_match) state_nxt = S_RINGING;
            end
            S_RINGING: begin
               if (dismiss)                              state_nxt = S_DONE;
               else if (snooze && (snooze_count < MAX_SNZ)) state_nxt = S_SNOOZE;
               else if (roll_seen == TIMEOUT)            state_nxt = S_DONE;
            end
            S_SNOOZE: begin
               if (dismiss)           state_nxt = S_DONE;
               else if (target_match) state_nxt = S_RINGING;
            end
            S_DONE: begin
               // stay quiet for the rest of the matching minute
               if (!time_match) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign enter_ring  = (state_nxt == S_RINGING) && (state != S_RINGING);
   assign take_snooze = (state == S_RINGING) && (state_nxt == S_SNOOZE);

   // ---------------- output / datapath next values ----------------
   always_comb begin
      beep_cnt_nxt       = beep_cnt;
      beep_phase_nxt     = beep_phase;
      roll_cnt_nxt       = roll_cnt;
      target_hours_nxt   = target_hours;
      target_minutes_nxt = target_minutes;
      snooze_count_nxt   = snooze_count;

      if (enter_ring) begin
         beep_cnt_nxt   = '0;
         beep_phase_nxt = 1'b1;
         roll_cnt_nxt   = '0;
      end else if (state == S_RINGING) begin
         roll_cnt_nxt = roll_seen;
         if (beep_cnt == HALF_LAST) begin
            beep_cnt_nxt   = '0;
            beep_phase_nxt = ~beep_phase;
         end else begin
            beep_cnt_nxt = beep_cnt + 1'b1;
         end
      end

      if (!alarm_enable) begin
         snooze_count_nxt = '0;
      end else if (enter_ring && (state == S_IDLE)) begin
         // a fresh alarm event; re-ring from SNOOZE keeps the count
         snooze_count_nxt = '0;
      end else if (take_snooze) begin
         snooze_count_nxt   = snooze_count + 3'd1;
         target_hours_nxt   = snz_h;
         target_minutes_nxt = snz_m;
      end

      ringing_nxt   = (state_nxt == S_RINGING);
      snoozed_nxt   = (state_nxt == S_SNOOZE);
      buzzer_on_nxt = ringing_nxt & beep_phase_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         beep_cnt       <= '0;
         beep_phase     <= 1'b0;
         prev_minutes   <= '0;
         roll_cnt       <= '0;
         target_hours   <= '0;
         target_minutes <= '0;
         snooze_count   <= '0;
         ringing        <= 1'b0;
         snoozed        <= 1'b0;
         buzzer_on      <= 1'b0;
      end else begin
         beep_cnt       <= beep_cnt_nxt;
         beep_phase     <= beep_phase_nxt;
         prev_minutes   <= time_minutes;
         roll_cnt       <= roll_cnt_nxt;
         target_hours   <= target_hours_nxt;
         target_minutes <= target_minutes_nxt;
         snooze_count   <= snooze_count_nxt;
         ringing        <= ringing_nxt;
         snoozed        <= snoozed_nxt;
         buzzer_on      <= buzzer_on_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_responder.sv
// Bench for alarm_responder: scenario tasks push expected outputs per cycle and compare when the cycle completes.
// Latency: expectation for stimulus applied before an edge is checked 1 time unit after that edge.
// Backpressure: none; the bench steps one clock per stimulus row.
module tb_alarm_responder;

   logic       MAX10_CLK1_50 = 1'b0;
   logic       reset_n;
   logic       alarm_enable;
   logic [4:0] time_hours;
   logic [5:0] time_minutes;
   logic [4:0] alarm_hours;
   logic [5:0] alarm_minutes;
   logic       snooze;
   logic       dismiss;
   logic       buzzer_on;
   logic       ringing;
   logic       snoozed;
   logic [2:0] snooze_count;

   typedef struct packed {
      logic       ring;
      logic       buzz;
      logic       snz;
      logic [2:0] cnt;
   } obs_t;

   obs_t  exp_q[$];
   obs_t  got_q[$];
   string nm_q[$];

   int checks = 0;
   int errors = 0;

   alarm_responder #(
      .CLK_HZ(8), .BEEP_HZ(2), .SNOOZE_MIN(5), .TIMEOUT_MIN(2), .MAX_SNOOZE(1)
   ) dut (
      .clk          (MAX10_CLK1_50),
      .reset_n      (reset_n),
      .alarm_enable (alarm_enable),
      .time_hours   (time_hours),
      .time_minutes (time_minutes),
      .alarm_hours  (alarm_hours),
      .alarm_minutes(alarm_minutes),
      .snooze       (snooze),
      .dismiss      (dismiss),
      .buzzer_on    (buzzer_on),
      .ringing      (ringing),
      .snoozed      (snoozed),
      .snooze_count (snooze_count)
   );

   always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

   // Drive one cycle of stimulus, record the expectation, then capture what the DUT shows after the edge.
   task automatic cyc(input string nm, input int h, input int m, input logic s, input logic d,
                      input logic r, input logic b, input logic z, input int c);
      obs_t e;
      time_hours   = 5'(h);
      time_minutes = 6'(m);
      snooze       = s;
      dismiss      = d;
      e.ring = r; e.buzz = b; e.snz = z; e.cnt = 3'(c);
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge MAX10_CLK1_50);
      #1;
      got_q.push_back({ringing, buzzer_on, snoozed, snooze_count});
      snooze  = 1'b0;
      dismiss = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; alarm_enable = 1'b1;
      alarm_hours = 5'd7; alarm_minutes = 6'd30;
      cyc("rst_hold0", 7, 30, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("rst_hold1", 7, 30, 1'b1, 1'b0, 0, 0, 0, 0);
      reset_n = 1'b1;
      cyc("rst_idle", 7, 29, 1'b0, 1'b0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   task automatic test_ring_beep();
      cyc("pre_match", 7, 29, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("beep1", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("beep2", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("beep3", 7, 30, 1'b0, 1'b0, 1, 0, 0, 0);
      cyc("beep4", 7, 30, 1'b0, 1'b0, 1, 0, 0, 0);
      cyc("beep5", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("beep6", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("beep7", 7, 30, 1'b0, 1'b0, 1, 0, 0, 0);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   task automatic test_dismiss();
      // continues from ringing at 07:30
      cyc("dismiss", 7, 30, 1'b0, 1'b1, 0, 0, 0, 0);
      cyc("done_hold0", 7, 30, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("done_hold1", 7, 30, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("idle_0731", 7, 31, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("snooze_idle", 7, 31, 1'b1, 1'b0, 0, 0, 0, 0);
      cyc("dismiss_idle", 7, 31, 1'b0, 1'b1, 0, 0, 0, 0);
      // back in IDLE, so the matching minute rings again
      cyc("rering", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("dismiss2", 7, 30, 1'b0, 1'b1, 0, 0, 0, 0);
      cyc("leave", 7, 31, 1'b0, 1'b0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   task automatic test_snooze_wrap();
      alarm_hours = 5'd23; alarm_minutes = 6'd58;
      cyc("w_pre", 23, 57, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("w_ring", 23, 58, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("w_snooze", 23, 58, 1'b1, 1'b0, 0, 0, 1, 1);
      cyc("w_2359", 23, 59, 1'b0, 1'b0, 0, 0, 1, 1);
      cyc("w_0000", 0, 0, 1'b0, 1'b0, 0, 0, 1, 1);
      cyc("w_0002", 0, 2, 1'b0, 1'b0, 0, 0, 1, 1);
      cyc("w_0003", 0, 3, 1'b0, 1'b0, 1, 1, 0, 1);
      cyc("w_snz_max", 0, 3, 1'b1, 1'b0, 1, 1, 0, 1);
      cyc("w_still", 0, 3, 1'b0, 1'b0, 1, 0, 0, 1);
      cyc("w_dismiss", 0, 3, 1'b0, 1'b1, 0, 0, 0, 1);
      cyc("w_idle", 0, 4, 1'b0, 1'b0, 0, 0, 0, 1);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   task automatic test_timeout();
      alarm_hours = 5'd7; alarm_minutes = 6'd30;
      cyc("t_pre", 7, 29, 1'b0, 1'b0, 0, 0, 0, 1);
      cyc("t_ring", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("t_roll1", 7, 31, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("t_hold", 7, 31, 1'b0, 1'b0, 1, 0, 0, 0);
      cyc("t_roll2", 7, 32, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("t_after", 7, 32, 1'b0, 1'b0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   task automatic test_snooze_dismiss_same();
      cyc("sd_pre", 7, 29, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("sd_ring", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("sd_both", 7, 30, 1'b1, 1'b1, 0, 0, 0, 0);
      cyc("sd_done", 7, 30, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("sd_idle", 7, 31, 1'b0, 1'b0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   task automatic test_abort();
      // reset while ringing after a snooze
      cyc("ab_pre", 7, 29, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("ab_ring", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("ab_snz", 7, 30, 1'b1, 1'b0, 0, 0, 1, 1);
      cyc("ab_rering", 7, 35, 1'b0, 1'b0, 1, 1, 0, 1);
      reset_n = 1'b0;
      cyc("ab_reset", 7, 35, 1'b0, 1'b0, 0, 0, 0, 0);
      reset_n = 1'b1;
      cyc("ab_post_rst", 7, 35, 1'b0, 1'b0, 0, 0, 0, 0);
      // alarm_enable drop while ringing after a snooze
      cyc("en_pre", 7, 29, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("en_ring", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      cyc("en_snz", 7, 30, 1'b1, 1'b0, 0, 0, 1, 1);
      cyc("en_rering", 7, 35, 1'b0, 1'b0, 1, 1, 0, 1);
      alarm_enable = 1'b0;
      cyc("en_off", 7, 35, 1'b0, 1'b0, 0, 0, 0, 0);
      cyc("en_off_match", 7, 30, 1'b0, 1'b0, 0, 0, 0, 0);
      alarm_enable = 1'b1;
      cyc("en_on_match", 7, 30, 1'b0, 1'b0, 1, 1, 0, 0);
      while (exp_q.size() > 0) begin
         obs_t e, g; string n;
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got ring=%0b buzz=%0b snz=%0b cnt=%0d expected ring=%0b buzz=%0b snz=%0b cnt=%0d",
                     n, g.ring, g.buzz, g.snz, g.cnt, e.ring, e.buzz, e.snz, e.cnt);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; alarm_enable = 1'b1;
      time_hours = '0; time_minutes = '0;
      alarm_hours = '0; alarm_minutes = '0;
      snooze = 1'b0; dismiss = 1'b0;
      test_reset();
      test_ring_beep();
      test_dismiss();
      test_snooze_wrap();
      test_timeout();
      test_snooze_dismiss_same();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
